// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory and decode-side bundle for fetch_sequencer
interface fetch_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [DATA_W-1:0] imem_rdata;
   logic              inst_valid;
   logic [ADDR_W-1:0] inst_pc;
   logic [DATA_W-1:0] inst_data;
   logic              inst_ready;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_pc, inst_data,
      input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_pc, inst_data,
      output imem_gnt, imem_rvalid, imem_rdata, inst_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and imem fetch sequencer; FETCH_PERF_CNT_EN adds perf counters
module fetch_sequencer #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_enable,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   fetch_sequencer_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_kill_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_pc;
   logic              kill;
   logic              req_q;
   logic              inst_valid_q;
   logic [ADDR_W-1:0] inst_pc_q;
   logic [DATA_W-1:0] inst_data_q;
   logic              outstanding;

   // A request is in flight if memory already accepted it and its response has not arrived yet
   assign outstanding = (state == WAIT && !bus.imem_rvalid) || (state == REQ && bus.imem_gnt);

   assign bus.imem_req   = req_q;
   assign bus.imem_addr  = pc;
   assign bus.inst_valid = inst_valid_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.inst_data  = inst_data_q;

   // Fetch FSM: redirect overrides every state, otherwise IDLE -> REQ -> WAIT -> HOLD
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         req_pc       <= '0;
         kill         <= 1'b0;
         req_q        <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_pc_q    <= '0;
         inst_data_q  <= '0;
      end else if (redirect_valid) begin
         pc           <= redirect_pc;
         inst_valid_q <= 1'b0;
         if (outstanding) begin
            // old-stream response still due; park in WAIT and drop it when it lands
            kill  <= 1'b1;
            state <= WAIT;
            req_q <= 1'b0;
         end else begin
            kill  <= 1'b0;
            state <= fetch_enable ? REQ : IDLE;
            req_q <= fetch_enable;
         end
      end else begin
         case (state)
            IDLE: begin
               if (fetch_enable) begin
                  state <= REQ;
                  req_q <= 1'b1;
               end
            end
            REQ: begin
               if (bus.imem_gnt) begin
                  pc     <= pc + PC_INC;
                  req_pc <= pc;
                  state  <= WAIT;
                  req_q  <= 1'b0;
               end else if (!fetch_enable) begin
                  state <= IDLE;
                  req_q <= 1'b0;
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  if (kill) begin
                     kill  <= 1'b0;
                     state <= fetch_enable ? REQ : IDLE;
                     req_q <= fetch_enable;
                  end else begin
                     inst_data_q  <= bus.imem_rdata;
                     inst_pc_q    <= req_pc;
                     inst_valid_q <= 1'b1;
                     state        <= HOLD;
                  end
               end
            end
            HOLD: begin
               // the next request waits one cycle so the output register is empty when it lands
               if (inst_valid_q && bus.inst_ready) begin
                  inst_valid_q <= 1'b0;
                  state        <= fetch_enable ? REQ : IDLE;
                  req_q        <= fetch_enable;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Free-running wrap-around event counters for decode handshakes, stalls and dropped responses
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
         perf_kill_cnt  <= '0;
      end else begin
         if (inst_valid_q && bus.inst_ready) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if (inst_valid_q && !bus.inst_ready) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (state == WAIT && bus.imem_rvalid && (kill || redirect_valid)) begin
            perf_kill_cnt <= perf_kill_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
